cond_seq_alu: RTL and testbench
===============================

# cond_seq_alu

Parametrised, clocked successor to the combinational ALU. It takes one operation per `start` pulse and applies a programmable barrel shift to operand 2. Execution is conditional on an internal NZCV flag register, and multiply runs as an iterative shift-add over `WIDTH` cycles with a busy/done handshake. It sits between register-file read and write-back, and the write-back stage consumes `result` on `done && executed`.

## Interface
- `WIDTH`, 32: datapath width. Must be ≥ 16.
- `SHAMT_W`, 5: shift-amount width. Equals clog2(`WIDTH`).

- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request. Accepted on a rising edge only when `busy` = 0.
- `op_code`, in, 4: operation select, see Operation.
- `shift_mode`, in, 2: operand-2 shift. 00 none, 01 LSR, 10 LSL, 11 ROR.
- `shamt`, in, `SHAMT_W`: shift amount.
- `cond`, in, 4: condition code.
- `set_flags`, in, 1: update NZCV on execution.
- `a`, in, `WIDTH`: operand 1.
- `b`, in, `WIDTH`: operand 2, pre-shift.
- `imm`, in, 16: immediate for MOVI.
- `busy`, out, 1: multiply in progress.
- `done`, out, 1: one-cycle completion pulse.
- `executed`, out, 1: qualifies `done`. 1 means the condition passed and the op was legal.
- `result`, out, `WIDTH`: registered result.
- `flags`, out, 4: registered {N, Z, C, V}.

## Operation
- **Operand 2.** `op2` = shift(`b`). `shamt` = 0 or mode 00 passes `b` unchanged with shifter carry `sc` = 0.
  - LSR/LSL: `sc` = last bit shifted out.
  - ROR: rotates by `shamt` mod `WIDTH`, and `sc` = `op2`[MSB].
- **Opcodes.**
  - 0 ADD: `a` + `op2`.
  - 1 SUB: `a` − `op2`.
  - 2 MUL: low `WIDTH` bits of `a` × `op2`.
  - 3 OR, 4 AND, 5 XOR: bitwise on `a` and `op2`.
  - 6 MOVI: zero-extended `imm`.
  - 7 MOV: `op2`.
  - 8 CMP: SUB without writing `result`. Always updates flags, regardless of `set_flags`.
  - 9–15: illegal. `done` = 1, `executed` = 0, no state change.
- **Conditions.** Evaluated against the registered `flags` at the accept edge.
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL always; 15 NV never.
  - On failure: `done` = 1, `executed` = 0, `result` and `flags` held.
- **Flags.** Written only when executed and (`set_flags` or CMP).
  - N = result MSB; Z = (result == 0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB/CMP: C = not-borrow (`a` ≥ `op2` unsigned); V = signed overflow.
  - MUL: C = 1 if any of the upper `WIDTH` product bits is nonzero; V = 0.
  - Logic/MOV/MOVI: C = `sc` (MOVI C = 0); V = 0.
- **Multiplier.** Two-state FSM: IDLE and MUL.
  - IDLE→MUL when MUL is accepted with the condition passing.
  - MUL holds a 2×`WIDTH` accumulator, a multiplier shift register and a counter, processing one bit per cycle.
  - MUL→IDLE when the counter reaches `WIDTH`.
  - Operands are latched at accept. Input changes during MUL have no effect.

## Timing
- **Reset.** Asynchronous. `result` = 0, `flags` = 0000, `busy` = 0, `done` = 0, `executed` = 0, FSM = IDLE.
  - Reset asserted mid-multiply aborts it immediately. There is no `done`.
- **Single-cycle ops, illegal ops and failed conditions.** Accept at edge k. `done`/`executed`/`result`/`flags` are valid after edge k, and `done` is low after edge k+1 unless a new op is accepted at k+1.
- **Back-to-back.** A new `start` is accepted every cycle while `busy` = 0, including the cycle in which `done` is high. Each op sees the flags written by the previous op.
- **MUL.**
  - Accept at edge k. `busy` = 1 after edge k.
  - After edge k+`WIDTH`: `busy` = 0, `done` = 1, and `result`/`flags` are updated.
  - A `start` while `busy` = 1 is ignored: not queued, no `done`.
  - A MUL with a failed condition never raises `busy`.

## Test plan
- **Reset abort.** `rst` pulsed 5 cycles into a MUL → all outputs 0 without waiting for a clock edge, no `done` afterwards, and the next ADD completes normally.
- **Carry and zero.** ADD `a`=0xFFFFFFFF, `b`=1, `set_flags`=1 → `result`=0, `flags`=0110, `done`=`executed`=1 one cycle after accept.
- **Shift and compare.** SUB `a`=0x10, `b`=1, LSL 4 → `result`=0, `flags`=0110. Then CMP `a`=5, `b`=7 → `flags`=1000 with `result` still 0.
- **Multiply latency and overflow.** MUL `a`=`b`=0x10000, `set_flags`=1 → `done` exactly 32 edges after accept, `result`=0, `flags`=0110. `start` pulses during `busy` produce no extra `done`.
- **Condition gating.** With `flags` Z=1: ADD `cond`=NE → `executed`=0, `result`/`flags` unchanged. Same ADD with `cond`=EQ → `executed`=1, `result` updated.
- **Rotate and illegal op.** MOV `b`=1, ROR 1, `set_flags`=1 → `result`=0x80000000, `flags`=1010. Then `op_code`=12 → `done`=1, `executed`=0, state unchanged.

Source files
------------

// File: rtl/cond_seq_alu.sv
// Conditional ALU with a barrel-shifted operand 2, an NZCV flag register and
// an iterative shift-add multiplier behind a busy/done handshake.
module cond_seq_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         op_code,
   input  logic [1:0]         shift_mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [3:0]         cond,
   input  logic               set_flags,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [15:0]        imm,
   output logic               busy,
   output logic               done,
   output logic               executed,
   output logic [WIDTH-1:0]   result,
   output logic [3:0]         flags
);
   typedef enum logic {S_IDLE, S_MUL} state_t;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_OR  = 4'd3, OP_AND = 4'd4,
      OP_XOR  = 4'd5, OP_MOVI = 4'd6, OP_MOV = 4'd7, OP_CMP = 4'd8
   } op_t;

   state_t               state;
   logic [WIDTH-1:0]     op2;
   logic                 sc;
   logic [2*WIDTH-1:0]   rot_pair;
   logic [SHAMT_W-1:0]   lsl_idx;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic                 legal;
   logic                 cond_pass;
   logic                 n_f, z_f, c_f, v_f;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]     mplier;
   logic [SHAMT_W-1:0]   cnt;
   logic                 mul_sf;

   // LSL carry is the bit at WIDTH-shamt; ROR takes the low half of {b,b} >> n
   always_comb begin
      op2      = b;
      sc       = 1'b0;
      rot_pair = {b, b} >> (int'(shamt) % WIDTH);
      lsl_idx  = SHAMT_W'(WIDTH - int'(shamt));
      if (shamt != '0) begin
         case (shift_mode)
            2'b01: begin
               op2 = b >> shamt;
               sc  = b[shamt - SHAMT_W'(1)];
            end
            2'b10: begin
               op2 = b << shamt;
               sc  = b[lsl_idx];
            end
            2'b11: begin
               op2 = rot_pair[WIDTH-1:0];
               sc  = rot_pair[WIDTH-1];
            end
            default: ;
         endcase
      end
   end

   assign sum  = {1'b0, a} + {1'b0, op2};
   assign diff = {1'b0, a} - {1'b0, op2};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      legal   = 1'b1;
      case (op_code)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = ~diff[WIDTH];
            alu_v   = (a[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: ;
         OP_OR:   begin alu_res = a | op2; alu_c = sc; end
         OP_AND:  begin alu_res = a & op2; alu_c = sc; end
         OP_XOR:  begin alu_res = a ^ op2; alu_c = sc; end
         OP_MOVI: alu_res = WIDTH'(imm);
         OP_MOV:  begin alu_res = op2; alu_c = sc; end
         default: legal = 1'b0;
      endcase
   end

   assign {n_f, z_f, c_f, v_f} = flags;

   always_comb begin
      case (cond)
         4'd0:    cond_pass = z_f;
         4'd1:    cond_pass = !z_f;
         4'd2:    cond_pass = c_f;
         4'd3:    cond_pass = !c_f;
         4'd4:    cond_pass = n_f;
         4'd5:    cond_pass = !n_f;
         4'd6:    cond_pass = v_f;
         4'd7:    cond_pass = !v_f;
         4'd8:    cond_pass = c_f && !z_f;
         4'd9:    cond_pass = !c_f || z_f;
         4'd10:   cond_pass = (n_f == v_f);
         4'd11:   cond_pass = (n_f != v_f);
         4'd12:   cond_pass = !z_f && (n_f == v_f);
         4'd13:   cond_pass = z_f || (n_f != v_f);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         executed <= 1'b0;
         result   <= '0;
         flags    <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         mul_sf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  executed <= 1'b0;
                  if (!(legal && cond_pass)) begin
                     done <= 1'b1;
                  end else if (op_code == OP_MUL) begin
                     state  <= S_MUL;
                     busy   <= 1'b1;
                     acc    <= '0;
                     mcand  <= (2*WIDTH)'(a);
                     mplier <= op2;
                     cnt    <= '0;
                     mul_sf <= set_flags;
                  end else begin
                     done     <= 1'b1;
                     executed <= 1'b1;
                     if (op_code != OP_CMP)
                        result <= alu_res;
                     if (set_flags || op_code == OP_CMP)
                        flags <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + SHAMT_W'(1);
               if (cnt == SHAMT_W'(WIDTH - 1)) begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  executed <= 1'b1;
                  result   <= acc_nxt[WIDTH-1:0];
                  if (mul_sf)
                     flags <= {acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0,
                               |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cond_seq_alu.sv
// Bench for cond_seq_alu: a 64-bit arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_cond_seq_alu;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [3:0]  op_code = '0;
   logic [1:0]  shift_mode = '0;
   logic [4:0]  shamt = '0;
   logic [3:0]  cond = 4'd14;
   logic        set_flags = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [15:0] imm = '0;
   logic        busy, done, executed;
   logic [31:0] result;
   logic [3:0]  flags;

   int errors = 0, checks = 0;
   logic checking = 1'b0;

   always #5 clk = ~clk;

   cond_seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op_code(op_code), .shift_mode(shift_mode),
      .shamt(shamt), .cond(cond), .set_flags(set_flags), .a(a), .b(b), .imm(imm),
      .busy(busy), .done(done), .executed(executed), .result(result), .flags(flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         0: return z;        1: return !z;
         2: return cy;       3: return !cy;
         4: return n;        5: return !n;
         6: return v;        7: return !v;
         8: return cy && !z; 9: return !cy || z;
         10: return n == v;  11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_eval(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                                      input logic [1:0] m, input logic [4:0] sh, input logic [15:0] im,
                                      output logic lg, output logic [31:0] res, output logic c, output logic v);
      logic [63:0] t;
      logic [31:0] o2;
      logic sc;
      longint sr;
      o2 = bb; sc = 1'b0;
      if (m != 2'd0 && sh != 5'd0) begin
         case (m)
            2'd1: begin t = {bb, 32'h0} >> sh; o2 = t[63:32]; sc = t[31]; end
            2'd2: begin t = {32'h0, bb} << sh; o2 = t[31:0]; sc = t[32]; end
            default: begin
               for (int i = 0; i < int'(sh); i++) o2 = {o2[0], o2[31:1]};
               sc = o2[31];
            end
         endcase
      end
      lg = 1'b1; res = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            t = 64'(aa) + 64'(o2); res = t[31:0]; c = t[32];
            sr = longint'($signed(aa)) + longint'($signed(o2));
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd1, 4'd8: begin
            res = aa - o2; c = (aa >= o2);
            sr = longint'($signed(aa)) - longint'($signed(o2));
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd2: begin t = 64'(aa) * 64'(o2); res = t[31:0]; c = (t[63:32] != 0); end
         4'd3: begin res = aa | o2; c = sc; end
         4'd4: begin res = aa & o2; c = sc; end
         4'd5: begin res = aa ^ o2; c = sc; end
         4'd6: res = {16'h0, im};
         4'd7: begin res = o2; c = sc; end
         default: lg = 1'b0;
      endcase
   endfunction

   logic [31:0] e_result, mul_res;
   logic [3:0]  e_flags, mul_fl;
   logic        e_done, e_exec, e_busy, mul_sf;
   int          mul_left;

   always @(posedge clk or posedge rst) begin : model
      logic lg, cc, vv;
      logic [31:0] r;
      if (rst) begin
         e_result <= '0; e_flags <= '0; e_done <= 1'b0; e_exec <= 1'b0; e_busy <= 1'b0;
         mul_left <= 0; mul_res <= '0; mul_fl <= '0; mul_sf <= 1'b0;
      end else begin
         e_done <= 1'b0;
         if (mul_left > 0) begin
            mul_left <= mul_left - 1;
            if (mul_left == 1) begin
               e_busy <= 1'b0; e_done <= 1'b1; e_exec <= 1'b1; e_result <= mul_res;
               if (mul_sf) e_flags <= mul_fl;
            end
         end else if (start) begin
            model_eval(op_code, a, b, shift_mode, shamt, imm, lg, r, cc, vv);
            e_done <= 1'b1; e_exec <= 1'b0;
            if (lg && cond_ok(cond, e_flags)) begin
               if (op_code == 4'd2) begin
                  e_done <= 1'b0; e_busy <= 1'b1; mul_left <= 32;
                  mul_res <= r; mul_fl <= {r[31], r == 0, cc, vv}; mul_sf <= set_flags;
               end else begin
                  e_exec <= 1'b1;
                  if (op_code != 4'd8) e_result <= r;
                  if (set_flags || op_code == 4'd8) e_flags <= {r[31], r == 0, cc, vv};
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checking && !rst) begin
         chk("m_done", done, e_done);
         chk("m_busy", busy, e_busy);
         chk("m_result", result, e_result);
         chk("m_flags", flags, e_flags);
         if (e_done) chk("m_executed", executed, e_exec);
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [1:0] m, input logic [4:0] sh, input logic [3:0] c, input logic sf);
      @(negedge clk);
      op_code = op; a = aa; b = bb; shift_mode = m; shamt = sh; cond = c; set_flags = sf; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      if (lat == 0) begin
         checks++; errors++;
         $display("FAIL %s: done never rose within 40 cycles", name);
      end
   endtask

   // back-to-back vectors: op, a, b, mode, shamt, cond, set_flags, imm
   logic [3:0]  v_op [10] = '{4'd6, 4'd0, 4'd0, 4'd5, 4'd4, 4'd1, 4'd2, 4'd3, 4'd8, 4'd15};
   logic [31:0] v_a  [10] = '{32'h0, 32'h7FFFFFFF, 32'h1, 32'hF0F0, 32'hFF, 32'h1, 32'h3, 32'h100, 32'h80000000, 32'h9};
   logic [31:0] v_b  [10] = '{32'h0, 32'h1, 32'h1, 32'hFF, 32'hF, 32'h2, 32'h4, 32'h80000001, 32'h1, 32'h9};
   logic [1:0]  v_m  [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
   logic [4:0]  v_sh [10] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0};
   logic [3:0]  v_c  [10] = '{4'd14, 4'd14, 4'd6, 4'd14, 4'd3, 4'd10, 4'd5, 4'd11, 4'd14, 4'd14};
   logic        v_sf [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      #1 rst = 1'b1;
      #20;
      chk("reset_result", result, 32'h0);
      chk("reset_flags", flags, 4'h0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_executed", executed, 1'b0);
      @(negedge clk) rst = 1'b0;
      checking = 1'b1;

      // carry and zero
      issue(4'd0, 32'hFFFFFFFF, 32'h1, 2'd0, 5'd0, 4'd14, 1'b1);
      chk("add_done", done, 1'b1);
      chk("add_exec", executed, 1'b1);
      chk("add_result", result, 32'h0);
      chk("add_flags", flags, 4'b0110);

      // condition gating with Z=1
      issue(4'd0, 32'h3, 32'h4, 2'd0, 5'd0, 4'd1, 1'b1);
      chk("ne_done", done, 1'b1);
      chk("ne_exec", executed, 1'b0);
      chk("ne_result", result, 32'h0);
      chk("ne_flags", flags, 4'b0110);
      issue(4'd0, 32'h3, 32'h4, 2'd0, 5'd0, 4'd0, 1'b0);
      chk("eq_exec", executed, 1'b1);
      chk("eq_result", result, 32'h7);

      // shift and compare
      issue(4'd1, 32'h10, 32'h1, 2'd2, 5'd4, 4'd14, 1'b1);
      chk("sub_result", result, 32'h0);
      chk("sub_flags", flags, 4'b0110);
      issue(4'd8, 32'h5, 32'h7, 2'd0, 5'd0, 4'd14, 1'b0);
      chk("cmp_flags", flags, 4'b1000);
      chk("cmp_result", result, 32'h0);

      // multiply latency, overflow and ignored starts while busy
      issue(4'd2, 32'h10000, 32'h10000, 2'd0, 5'd0, 4'd14, 1'b1);
      chk("mul_busy", busy, 1'b1);
      chk("mul_nodone", done, 1'b0);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         start = (i >= 3 && i <= 8);
         op_code = 4'd0;
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      start = 1'b0;
      chk("mul_latency", 32'(lat), 32'd32);
      chk("mul_result", result, 32'h0);
      chk("mul_flags", flags, 4'b0110);
      chk("mul_exec", executed, 1'b1);
      @(negedge clk);
      chk("mul_single_done", done, 1'b0);

      // rotate and illegal op
      issue(4'd7, 32'h0, 32'h1, 2'd3, 5'd1, 4'd14, 1'b1);
      chk("ror_result", result, 32'h80000000);
      chk("ror_flags", flags, 4'b1010);
      issue(4'd12, 32'h5, 32'h5, 2'd0, 5'd0, 4'd14, 1'b1);
      chk("ill_done", done, 1'b1);
      chk("ill_exec", executed, 1'b0);
      chk("ill_result", result, 32'h80000000);
      chk("ill_flags", flags, 4'b1010);

      // back-to-back stream, start held high
      for (int i = 0; i < 10; i++) begin
         op_code = v_op[i]; a = v_a[i]; b = v_b[i]; shift_mode = v_m[i]; shamt = v_sh[i];
         cond = v_c[i]; set_flags = v_sf[i]; imm = 16'h1234; start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);

      // a multiply with a nontrivial product, flags left alone
      issue(4'd2, 32'hDEADBEEF, 32'h1234, 2'd0, 5'd0, 4'd14, 1'b0);
      wait_done("mul2", lat);
      @(negedge clk);

      // reset mid-multiply
      issue(4'd2, 32'h3, 32'h5, 2'd0, 5'd0, 4'd14, 1'b1);
      repeat (4) @(negedge clk);
      chk("abort_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_result", result, 32'h0);
      chk("abort_flags", flags, 4'h0);
      chk("abort_exec", executed, 1'b0);
      @(negedge clk) rst = 1'b0;
      repeat (40) @(negedge clk);
      issue(4'd0, 32'h2, 32'h3, 2'd0, 5'd0, 4'd14, 1'b1);
      chk("post_reset_done", done, 1'b1);
      chk("post_reset_result", result, 32'h5);
      chk("post_reset_flags", flags, 4'b0000);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
